// File: rtl/rk_tape_enc.sv
// rk_tape_enc: phase-encoded byte serialiser for cassette tape, MSB first, two half-cells per bit.
// Rev 1.0. Define RK_TAPE_FIFO_EN for a 4-entry byte FIFO; otherwise a single holding register.
`default_nettype none

module rk_tape_enc #(
  parameter int HALF_BIT_CLKS = 13000
) (
  input  logic       CLK,
  input  logic       N_RESET,
  input  logic       WR,
  input  logic [7:0] DI,
  input  logic       CLR_OVF,
  output logic       TAPE_OUT,
  output logic       BUSY,
  output logic       READY,
  output logic       OVF
);

  localparam logic [15:0] HALF_RELOAD = 16'(HALF_BIT_CLKS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_SECOND = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tape_q, tape_d;
  logic        ovf_q, ovf_d;

  logic       half_done;
  logic       load_half;
  logic       next_bit;
  logic       pop;
  logic       push;
  logic       buf_full;
  logic       buf_empty;
  logic [7:0] pop_data;
  logic       busy_o;

  // A full buffer still accepts a write when the same edge frees a slot.
  assign push      = WR & (~buf_full | pop);
  assign half_done = (timer_q == 16'd0);

`ifdef RK_TAPE_FIFO_EN
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = DI;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign buf_full  = (count_q == 3'd4);
  assign buf_empty = (count_q == 3'd0);
  assign pop_data  = mem_q[rd_ptr_q];
`else
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (push) begin
      hold_d = DI;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end

  assign buf_full  = full_q;
  assign buf_empty = ~full_q;
  assign pop_data  = hold_q;
`endif

  // State register
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_half = 1'b0;
    next_bit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!buf_empty) begin
          state_d   = S_FIRST;
          pop       = 1'b1;
          load_half = 1'b1;
        end
      end
      S_FIRST: begin
        if (half_done) begin
          state_d   = S_SECOND;
          load_half = 1'b1;
        end
      end
      S_SECOND: begin
        if (half_done) begin
          if (bit_cnt_q != 3'd7) begin
            state_d   = S_FIRST;
            load_half = 1'b1;
            next_bit  = 1'b1;
          end else if (!buf_empty) begin
            state_d   = S_FIRST;
            pop       = 1'b1;
            load_half = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; the tape level is registered, so it trails the state by one edge.
  always_comb begin
    busy_o = (state_q != S_IDLE);
    case (state_q)
      S_FIRST:  tape_d = ~shift_q[7];
      S_SECOND: tape_d = shift_q[7];
      default:  tape_d = tape_q;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    if (pop) begin
      shift_d   = pop_data;
      bit_cnt_d = 3'd0;
    end else if (next_bit) begin
      shift_d   = {shift_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (load_half) begin
      timer_d = HALF_RELOAD;
    end else if (!half_done) begin
      timer_d = timer_q - 16'd1;
    end
    ovf_d = (ovf_q & ~CLR_OVF) | (WR & buf_full & ~pop);
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      timer_q   <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      tape_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tape_q    <= tape_d;
      ovf_q     <= ovf_d;
    end
  end

  assign TAPE_OUT = tape_q;
  assign BUSY     = busy_o;
  assign READY    = ~buf_full;
  assign OVF      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rk_tape_enc.sv
// tb_rk_tape_enc: directed and random stimulus for rk_tape_enc against a queue-based reference model.
// Rev 1.0. Buffer depth of the model follows RK_TAPE_FIFO_EN.
`default_nettype none

module tb_rk_tape_enc;

  localparam int H = 4;
`ifdef RK_TAPE_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int BYTE_CLKS = 16 * H;

  logic       CLK = 1'b0;
  logic       N_RESET = 1'b0;
  logic       WR = 1'b0;
  logic [7:0] DI = 8'h00;
  logic       CLR_OVF = 1'b0;
  logic       TAPE_OUT;
  logic       BUSY;
  logic       READY;
  logic       OVF;

  rk_tape_enc #(.HALF_BIT_CLKS(H)) dut (
    .CLK      (CLK),
    .N_RESET  (N_RESET),
    .WR       (WR),
    .DI       (DI),
    .CLR_OVF  (CLR_OVF),
    .TAPE_OUT (TAPE_OUT),
    .BUSY     (BUSY),
    .READY    (READY),
    .OVF      (OVF)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes, byte in flight and cycle offset within it.
  logic [7:0] m_q [$];
  logic [7:0] m_cur;
  int         m_k;
  bit         m_busy;
  logic       m_tape;
  bit         m_ovf;

  logic [63:0] hist;
  int          busy_cnt;
  int          rises;
  logic        prev_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic level(input logic [7:0] b, input int kk);
    logic bv;
    bv = b[7 - kk / (2 * H)];
    return (((kk / H) % 2) == 0) ? ~bv : bv;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur  = 8'h00;
    m_k    = 0;
    m_busy = 0;
    m_tape = 1'b0;
    m_ovf  = 0;
  endtask

  task automatic model_edge(input logic wr, input logic [7:0] di, input logic clr);
    bit ovfl;
    ovfl = 0;
    if (m_busy) m_tape = level(m_cur, m_k);
    if (m_busy && m_k < BYTE_CLKS - 1) begin
      m_k++;
    end else if (m_q.size() > 0) begin
      m_cur  = m_q.pop_front();
      m_k    = 0;
      m_busy = 1;
    end else begin
      m_busy = 0;
    end
    if (wr) begin
      if (m_q.size() < DEPTH) m_q.push_back(di);
      else ovfl = 1;
    end
    m_ovf = (m_ovf && !clr) || ovfl;
  endtask

  task automatic step(input logic wr, input logic [7:0] di, input logic clr);
    WR      = wr;
    DI      = di;
    CLR_OVF = clr;
    @(posedge CLK);
    model_edge(wr, di, clr);
    @(negedge CLK);
    check("tape",  TAPE_OUT, m_tape);
    check("busy",  BUSY,     m_busy);
    check("ready", READY,    m_q.size() < DEPTH);
    check("ovf",   OVF,      m_ovf);
    WR      = 1'b0;
    CLR_OVF = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    N_RESET = 1'b0;
    WR      = 1'b0;
    CLR_OVF = 1'b0;
    #1;
    check("rst_tape",  TAPE_OUT, 1'b0);
    check("rst_busy",  BUSY,     1'b0);
    check("rst_ready", READY,    1'b1);
    check("rst_ovf",   OVF,      1'b0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    N_RESET = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check("por_tape",  TAPE_OUT, 1'b0);
    check("por_busy",  BUSY,     1'b0);
    check("por_ready", READY,    1'b1);
    check("por_ovf",   OVF,      1'b0);
    @(negedge CLK);
    @(negedge CLK);
    N_RESET = 1'b1;

    // Single byte A5 from idle: two-edge latency, 64 busy cycles.
    step(1'b1, 8'hA5, 1'b0);
    busy_cnt = 0;
    step(1'b0, 8'h00, 1'b0);
    if (BUSY) busy_cnt++;
    hist = '0;
    for (int i = 0; i < BYTE_CLKS; i++) begin
      step(1'b0, 8'h00, 1'b0);
      hist = {hist[62:0], TAPE_OUT};
      if (BUSY) busy_cnt++;
    end
    check("a5_pattern", hist, 64'h0FF00FF0F00FF00F);
    check("a5_busy_cycles", busy_cnt, 64);
    idle(4);
    check("a5_idle_hold", TAPE_OUT, 1'b1);

    // 00 then FF back to back: one continuous 128-cycle busy window.
    step(1'b1, 8'h00, 1'b0);
    busy_cnt  = 0;
    rises     = 0;
    prev_busy = 1'b0;
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 2 * BYTE_CLKS + 4; i++) begin
      if (BUSY) busy_cnt++;
      if (BUSY && !prev_busy) rises++;
      prev_busy = BUSY;
      step(1'b0, 8'h00, 1'b0);
    end
    check("b2b_busy_cycles", busy_cnt, 128);
    check("b2b_busy_rises", rises, 1);

    // Three consecutive writes from idle.
    do_reset();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    check("three_wr_ovf", OVF, DEPTH == 1);
    idle(3 * BYTE_CLKS + 4);
    step(1'b0, 8'h00, 1'b1);
    check("clr_ovf", OVF, 1'b0);

    // Five consecutive writes 01..05.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    check("five_wr_ovf", OVF, DEPTH == 1);
    idle(5 * BYTE_CLKS + 4);

    // Reset in the middle of a byte, then a clean byte 80.
    do_reset();
    step(1'b1, 8'h55, 1'b0);
    idle(1 + 2 * H * 4 + H / 2);
    do_reset();
    step(1'b1, 8'h80, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    hist = '0;
    for (int i = 0; i < BYTE_CLKS; i++) begin
      step(1'b0, 8'h00, 1'b0);
      hist = {hist[62:0], TAPE_OUT};
    end
    check("post_rst_80", hist, 64'h0FF0F0F0F0F0F0F0);
    idle(4);

    // Write on the very edge that pops the next byte, with the buffer full.
    do_reset();
    step(1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    idle(BYTE_CLKS - DEPTH);
    check("edge_full_ready", READY, 1'b0);
    step(1'b1, 8'h9E, 1'b0);
    check("edge_wr_ovf", OVF, 1'b0);
    check("edge_wr_busy", BUSY, 1'b1);
    idle((DEPTH + 1) * BYTE_CLKS + 4);

    // Random traffic, including overflow and clear collisions.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
    end
    idle((DEPTH + 1) * BYTE_CLKS + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rk_tape_enc.md
RK_TAPE_ENC -- requirements
Module: rk_tape_enc

Interface
REQ-001 SHALL have parameter HALF_BIT_CLKS, default 13000, CLK cycles per half-bit cell (260 us at 50 MHz); legal range 2..65535.
REQ-002 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port N_RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port WR  input  1  one-cycle strobe offering DI for transmission.
REQ-005 SHALL have port DI  input  8  byte to transmit, sampled when WR=1.
REQ-006 SHALL have port CLR_OVF  input  1  one-cycle strobe clearing OVF.
REQ-007 SHALL have port TAPE_OUT  output  1  phase-encoded tape signal, registered.
REQ-008 SHALL have port BUSY  output  1  high while a byte is being shifted out.
REQ-009 SHALL have port READY  output  1  high when the byte buffer can accept a write.
REQ-010 SHALL have port OVF  output  1  sticky flag, set by a write to a full buffer.

Function
REQ-011 SHALL encode each bit b as two half-cells: first half TAPE_OUT=~b, second half TAPE_OUT=b; each half exactly HALF_BIT_CLKS cycles.
REQ-012 SHALL send bytes MSB first, 8 bits, no start/stop bits or inter-byte gap.
REQ-013 SHALL use FSM states IDLE, FIRST, SECOND: IDLE->FIRST on buffer non-empty (pop to shift register); FIRST->SECOND at half-timer expiry; SECOND->FIRST at expiry when bits remain; SECOND->FIRST with pop when last bit done and buffer non-empty; SECOND->IDLE when last bit done and buffer empty.
REQ-014 SHALL give write-to-output latency of 2 cycles from idle: WR sampled at edge n, pop/load at edge n+1, TAPE_OUT=~DI[7] after edge n+2.
REQ-015 SHALL hold a half-timer that reloads HALF_BIT_CLKS-1 at each half start and expires at 0; 16-bit counter, no wrap beyond reload.
REQ-016 SHALL hold TAPE_OUT at its last driven level in IDLE (no forced return to 0).
REQ-017 SHALL assert BUSY in FIRST and SECOND, deassert in IDLE; back-to-back bytes keep BUSY high continuously.
REQ-018 SHALL accept WR when buffer not full, or when full and a pop occurs in the same cycle.
REQ-019 SHALL ignore WR when full without simultaneous pop, leave buffer contents unchanged, and set OVF.
REQ-020 SHALL clear OVF on CLR_OVF; simultaneous CLR_OVF and overflowing WR leaves OVF=1.
REQ-021 SHALL derive READY combinationally from buffer not-full.

Reset
REQ-022 SHALL, while N_RESET=0, force state IDLE, buffer empty, timer and bit counter 0, TAPE_OUT=0, BUSY=0, READY=1, OVF=0.
REQ-023 SHALL abort any byte in progress on reset, with no partial half-cell after release.
REQ-024 SHALL ignore WR in the cycle N_RESET deasserts only if metastability-synchronised release is implemented; otherwise first edge after release samples WR normally.

Configuration
REQ-025 SHALL, with RK_TAPE_FIFO_EN defined, implement the buffer as a 4-entry FIFO (2-bit pointers, wrap 3->0, count 0..4).
REQ-026 SHALL, without RK_TAPE_FIFO_EN, implement the buffer as a single holding register (depth 1); all other behaviour identical.

Verification
REQ-027 SHALL cover: HALF_BIT_CLKS=4, WR DI=8'hA5 from idle -> TAPE_OUT after 2 cycles = 0000 1111 1111 0000 0000 1111 1111 0000 1111 0000 0000 1111 1111 0000 0000 1111 pattern per bits 1,0,1,0,0,1,0,1 (each 4 cycles), BUSY high 64 cycles.
REQ-028 SHALL cover: HALF_BIT_CLKS=4, WR 8'h00 then 8'hFF 1 cycle apart -> 128 contiguous cycles, BUSY never drops, no gap at byte boundary.
REQ-029 SHALL cover: no FIFO, 3 WRs on consecutive cycles while idle -> bytes 1,2 transmitted, byte 3 dropped, OVF=1; CLR_OVF -> OVF=0.
REQ-030 SHALL cover: RK_TAPE_FIFO_EN, 5 WRs (8'h01..8'h05) in consecutive cycles from idle -> all 5 sent in order, OVF=0, READY low only while count=4.
REQ-031 SHALL cover: N_RESET pulsed low mid-bit 3 of 8'h55 -> TAPE_OUT=0, BUSY=0, READY=1 immediately; next WR 8'h80 transmits cleanly from bit 7.
REQ-032 SHALL cover: WR on exact cycle of last-half expiry with buffer full -> write accepted, pop loads next byte, OVF stays 0.
